// File: rtl/instr_cache_refill_ctrl.sv
// instr_cache_refill_ctrl: fetches one cache line as 32-bit words and replays it as contiguous 64-bit beats.
module instr_cache_refill_ctrl #(
  parameter int B = 64,
  parameter int AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 CacheMiss,
  input  logic [AddrWidth-1:0] MissAddr,
  output logic                 MemReq,
  output logic [AddrWidth-1:0] MemAddr,
  input  logic                 MemReady,
  input  logic                 MemRValid,
  input  logic [31:0]          MemRData,
  output logic                 RepEnable,
  output logic [63:0]          RepWord,
  output logic                 RefillDone,
  output logic                 Busy
);
  localparam int WN = B / 4;
  localparam int BN = B / 8;
  localparam int WW = WN > 2 ? $clog2(WN) : 1;
  localparam int BW = BN > 2 ? $clog2(BN) : 1;
  typedef enum logic [2:0] {IDLE, REQ, FILL, STREAM, DONE} state_t;
  state_t state, state_d;
  logic [WW-1:0] wcnt, wcnt_d;
  logic [BW-1:0] bcnt, bcnt_d, bsel;
  logic [B*8-1:0] line, line_d;
  logic [AddrWidth-1:0] addr_d;
  logic [63:0] word_d;
  assign MemReq = state == REQ;
  assign RepEnable = state == STREAM;
  assign RefillDone = state == DONE;
  assign Busy = state != IDLE;
  assign bsel = bcnt + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt <= '0;
      bcnt <= '0;
      MemAddr <= '0;
      RepWord <= '0;
    end else begin
      state <= state_d;
      wcnt <= wcnt_d;
      bcnt <= bcnt_d;
      MemAddr <= addr_d;
      RepWord <= word_d;
    end
  end
  // Line contents need no reset: a partial line is never streamed.
  always_ff @(posedge clk) line <= line_d;
  always_comb begin
    state_d = state;
    wcnt_d = wcnt;
    bcnt_d = bcnt;
    addr_d = MemAddr;
    word_d = RepWord;
    line_d = line;
    if (state == FILL && MemRValid) line_d[32*wcnt +: 32] = MemRData;
    case (state)
      IDLE: if (CacheMiss) begin
        addr_d = MissAddr & ~AddrWidth'(B - 1);
        state_d = REQ;
      end
      REQ: if (MemReady) begin
        wcnt_d = '0;
        state_d = FILL;
      end
      // Beat 0 is preloaded from the bypassed line so RepWord is valid on the first STREAM cycle.
      FILL: if (MemRValid) begin
        wcnt_d = wcnt + 1'b1;
        if (wcnt == WW'(WN - 1)) begin
          bcnt_d = '0;
          word_d = line_d[63:0];
          state_d = STREAM;
        end
      end
      STREAM: if (bcnt == BW'(BN - 1)) state_d = DONE;
      else begin
        bcnt_d = bsel;
        word_d = line[64*bsel +: 64];
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule
